minibit_alu_seq: RTL and testbench

Multi-cycle controller that sequences the MiniBit ALU datapath (alu_decoder + alu) for one instruction at a time. It accepts an instruction byte and two operands over a valid/ready handshake and drives the decoder's opcode bus and the ALU's A/B inputs from registers. It latches the ALU result and the carry/less-than/zero flags, and returns the result over a second valid/ready handshake. It sits between the MiniBit fetch/issue logic and the combinational ALU pair. It owns the architectural flag register that feeds `fl_carry` back into the decoder.

---
 rtl/minibit_alu_seq.sv | 133 +++++++++++++
 tb/tb_minibit_alu_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/minibit_alu_seq.sv
// MiniBit ALU sequencer: issues one instruction at a time to the combinational
// decoder/ALU pair and owns the flag register. Optional macro: MINIBIT_ALU_REPEAT_EN.
module minibit_alu_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [7:0]   instr,
    input  logic [W-1:0] opa,
    input  logic [W-1:0] opb,
    output logic [7:0]   alu_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_o,
    input  logic         pre_carry,
    input  logic         pre_lt,
    input  logic         pre_z,
    output logic         fl_carry,
    output logic         fl_lt,
    output logic         fl_z,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state, state_nxt;
    logic [3:0]   op_r;
    logic [W-1:0] a_r;
    logic [W-1:0] b_r;
    logic [W-1:0] res_r;
    logic         more;

`ifdef MINIBIT_ALU_REPEAT_EN
    // cnt holds the number of passes still to run after the current one.
    logic [3:0]   cnt;
    assign more = (cnt != '0);
`else
    logic         instr_cnt_unused;
    assign more             = 1'b0;
    assign instr_cnt_unused = ^instr[3:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (instr_valid) state_nxt = EXEC;
            EXEC: if (!more)       state_nxt = DONE;
            DONE: if (res_ready)   state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        instr_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b0;
        case (state)
            IDLE:    instr_ready = 1'b1;
            EXEC:    busy        = 1'b1;
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
            end
            default: instr_ready = 1'b0;
        endcase
    end

    // Flags update only on EXEC edges, so the carry fed to the decoder is
    // stable for the whole of each pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r     <= '0;
            a_r      <= '0;
            b_r      <= '0;
            res_r    <= '0;
            fl_carry <= 1'b0;
            fl_lt    <= 1'b0;
            fl_z     <= 1'b0;
`ifdef MINIBIT_ALU_REPEAT_EN
            cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        op_r <= instr[7:4];
                        a_r  <= opa;
                        b_r  <= opb;
`ifdef MINIBIT_ALU_REPEAT_EN
                        cnt  <= instr[3:0];
`endif
                    end
                end
                EXEC: begin
                    res_r    <= alu_o;
                    fl_carry <= pre_carry;
                    fl_lt    <= pre_lt;
                    fl_z     <= pre_z;
                    if (more) begin
                        a_r <= alu_o;
`ifdef MINIBIT_ALU_REPEAT_EN
                        cnt <= cnt - 4'd1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_op = {op_r, 4'b0000};
    assign alu_a  = a_r;
    assign alu_b  = b_r;
    assign res    = res_r;

endmodule

// File: tb/tb_minibit_alu_seq.sv
// Self-checking bench for minibit_alu_seq with an adder-style ALU stand-in;
// honours MINIBIT_ALU_REPEAT_EN when the design is built with it.
module tb_minibit_alu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr;
    logic [7:0] opa, opb;
    logic [7:0] alu_op, alu_a, alu_b, alu_o;
    logic       pre_carry, pre_lt, pre_z;
    logic       fl_carry, fl_lt, fl_z;
    logic       res_valid, res_ready;
    logic [7:0] res;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    minibit_alu_seq #(.W(8)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .opa(opa), .opb(opb),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_o(alu_o),
        .pre_carry(pre_carry), .pre_lt(pre_lt), .pre_z(pre_z),
        .fl_carry(fl_carry), .fl_lt(fl_lt), .fl_z(fl_z),
        .res_valid(res_valid), .res_ready(res_ready), .res(res), .busy(busy)
    );

    // ALU stand-in: add, independent of alu_op.
    logic [8:0] sum9;
    assign sum9      = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_o     = sum9[7:0];
    assign pre_carry = sum9[8];
    assign pre_z     = (sum9[7:0] == 8'h00);
    assign pre_lt    = (alu_a < alu_b);

    typedef struct {
        logic [7:0] ins;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       c;
        logic       lt;
        logic       z;
        int         stall;
    } vec_t;

    typedef struct {
        logic [7:0] r;
        logic       c;
        logic       lt;
        logic       z;
    } exp_t;

    function automatic int n_passes(input logic [7:0] ins);
`ifdef MINIBIT_ALU_REPEAT_EN
        return int'(ins[3:0]) + 1;
`else
        return 1;
`endif
    endfunction

    // Reference: repeated a = a + b, flags from the final addition.
    function automatic exp_t model(input logic [7:0] ins, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   acc;
        acc = int'(a);
        e = '{r: 8'h00, c: 1'b0, lt: 1'b0, z: 1'b0};
        for (int p = 0; p < n_passes(ins); p++) begin
            e.lt = (acc < int'(b));
            acc  = acc + int'(b);
            e.c  = (acc > 255);
            acc  = acc % 256;
            e.r  = acc[7:0];
            e.z  = (acc == 0);
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one instruction from IDLE and follows it through to consumption.
    task automatic run_instr(input logic [7:0] ins, input logic [7:0] a, input logic [7:0] b,
                             input exp_t e, input int passes, input int stall);
        int lat;
        @(negedge clk);
        check("ready_idle", {31'd0, instr_ready}, 32'd1);
        instr_valid = 1'b1;
        instr       = ins;
        opa         = a;
        opb         = b;
        res_ready   = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        opa         = 8'($urandom);
        opb         = 8'($urandom);
        instr       = 8'($urandom);
        check("alu_op_exec", {24'd0, alu_op}, {24'd0, ins[7:4], 4'h0});
        check("alu_a_exec", {24'd0, alu_a}, {24'd0, a});
        check("alu_b_exec", {24'd0, alu_b}, {24'd0, b});
        check("busy_exec", {31'd0, busy}, 32'd1);
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, passes);
        check("res", {24'd0, res}, {24'd0, e.r});
        check("flags", {29'd0, fl_carry, fl_lt, fl_z}, {29'd0, e.c, e.lt, e.z});
        check("ready_busy", {31'd0, instr_ready}, 32'd0);
        for (int i = 0; i < stall; i++) begin
            instr_valid = (i == 2);
            instr       = 8'h7F;
            opa         = 8'h33;
            opb         = 8'h44;
            @(negedge clk);
            check("stall_valid", {31'd0, res_valid}, 32'd1);
            check("stall_res", {24'd0, res}, {24'd0, e.r});
            check("stall_flags", {29'd0, fl_carry, fl_lt, fl_z}, {29'd0, e.c, e.lt, e.z});
            check("stall_ready", {31'd0, instr_ready}, 32'd0);
        end
        instr_valid = 1'b0;
        res_ready   = 1'b1;
        @(negedge clk);
        check("consumed", {30'd0, res_valid, busy}, 32'd0);
        check("ready_after", {31'd0, instr_ready}, 32'd1);
        check("flags_persist", {29'd0, fl_carry, fl_lt, fl_z}, {29'd0, e.c, e.lt, e.z});
        if (stall > 0) begin
            @(negedge clk);
            check("stall_pulse_ignored", {31'd0, busy}, 32'd0);
        end
    endtask

    vec_t vecs[6];

    initial begin
        exp_t e;
        logic [7:0] ri, ra, rb;
        int seen;

        vecs[0] = '{ins: 8'h20, a: 8'h04, b: 8'h04, r: 8'h08, c: 1'b0, lt: 1'b0, z: 1'b0, stall: 0};
        vecs[1] = '{ins: 8'h60, a: 8'hFF, b: 8'h01, r: 8'h00, c: 1'b1, lt: 1'b0, z: 1'b1, stall: 0};
        vecs[2] = '{ins: 8'h10, a: 8'h03, b: 8'h05, r: 8'h08, c: 1'b0, lt: 1'b1, z: 1'b0, stall: 5};
        vecs[3] = '{ins: 8'h30, a: 8'h80, b: 8'h80, r: 8'h00, c: 1'b1, lt: 1'b0, z: 1'b1, stall: 0};
        vecs[4] = '{ins: 8'h40, a: 8'hF0, b: 8'h20, r: 8'h10, c: 1'b1, lt: 1'b0, z: 1'b0, stall: 0};
`ifdef MINIBIT_ALU_REPEAT_EN
        vecs[5] = '{ins: 8'h23, a: 8'h01, b: 8'h01, r: 8'h05, c: 1'b0, lt: 1'b0, z: 1'b0, stall: 0};
`else
        vecs[5] = '{ins: 8'h23, a: 8'h01, b: 8'h01, r: 8'h02, c: 1'b0, lt: 1'b0, z: 1'b0, stall: 0};
`endif

        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 8'h00;
        opa         = 8'h00;
        opb         = 8'h00;
        res_ready   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ctrl", {29'd0, instr_ready, res_valid, busy}, 32'h4);
        check("rst_alu_op", {24'd0, alu_op}, 32'h0);
        check("rst_res", {24'd0, res}, 32'h0);
        check("rst_ab", {16'd0, alu_a, alu_b}, 32'h0);
        check("rst_flags", {29'd0, fl_carry, fl_lt, fl_z}, 32'h0);

        for (int i = 0; i < 6; i++) begin
            e = '{r: vecs[i].r, c: vecs[i].c, lt: vecs[i].lt, z: vecs[i].z};
            run_instr(vecs[i].ins, vecs[i].a, vecs[i].b, e, n_passes(vecs[i].ins), vecs[i].stall);
            if (i == 1) check("carry_to_decoder", {31'd0, fl_carry}, 32'd1);
        end

        for (int i = 0; i < 30; i++) begin
            ri = 8'($urandom);
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_instr(ri, ra, rb, model(ri, ra, rb), n_passes(ri), (i % 7 == 3) ? 2 : 0);
        end

        // Leave a set carry behind, then reset in the middle of a long instruction.
        run_instr(8'h50, 8'hC0, 8'h80, model(8'h50, 8'hC0, 8'h80), 1, 0);
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = 8'h2F;
        opa         = 8'h01;
        opb         = 8'h01;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_ctrl", {29'd0, instr_ready, res_valid, busy}, 32'h4);
        check("midrst_flags", {29'd0, fl_carry, fl_lt, fl_z}, 32'h0);
        check("midrst_data", {16'd0, res, alu_op}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid || busy) seen++;
        end
        check("midrst_no_result", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
